// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the game progress tracker
package game_pkg;

    localparam int POS_W      = 10;
    localparam int PELLET_PTS = 10;
    localparam int POWER_PTS  = 50;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PLAY        = 3'd1,
        DYING       = 3'd2,
        WAIT_REPLAY = 3'd3,
        OVER        = 3'd4,
        WON         = 3'd5
    } gs_state_t;

endpackage

// File: rtl/game_status_if.sv
// rtl/game_status_if.sv - control/position inputs and progress outputs of game_status
interface game_status_if
    import game_pkg::*;
#(
    parameter int NUM_GHOSTS = 4
);

    logic                        restart;
    logic                        replay;
    logic                        isIntro;
    logic                        frame_tick;
    logic                        pellet_eaten;
    logic                        power_eaten;
    logic [POS_W-1:0]            pac_x;
    logic [POS_W-1:0]            pac_y;
    logic [POS_W*NUM_GHOSTS-1:0] ghost_x;
    logic [POS_W*NUM_GHOSTS-1:0] ghost_y;

    logic                        fail;
    logic                        finish;
    logic                        freeze;
    logic [2:0]                  lives;
    logic [15:0]                 score;
    logic [7:0]                  pellets_left;
    logic                        game_won;

    // Control FSM, video timing and sprite logic side
    modport master (
        output restart, replay, isIntro, frame_tick, pellet_eaten, power_eaten,
        output pac_x, pac_y, ghost_x, ghost_y,
        input  fail, finish, freeze, lives, score, pellets_left, game_won
    );

    // Tracker side
    modport slave (
        input  restart, replay, isIntro, frame_tick, pellet_eaten, power_eaten,
        input  pac_x, pac_y, ghost_x, ghost_y,
        output fail, finish, freeze, lives, score, pellets_left, game_won
    );

endinterface

// File: rtl/hit_detect.sv
// rtl/hit_detect.sv - Pac-Man versus single-ghost proximity test
module hit_detect
    import game_pkg::*;
#(
    parameter int HIT_DIST = 8
) (
    input  logic [POS_W-1:0] pac_x,
    input  logic [POS_W-1:0] pac_y,
    input  logic [POS_W-1:0] ghost_x,
    input  logic [POS_W-1:0] ghost_y,
    output logic             hit
);

    localparam logic [POS_W-1:0] HIT_LIM = POS_W'(HIT_DIST);

    logic [POS_W-1:0] dx;
    logic [POS_W-1:0] dy;

    // Absolute distance per axis; a hit needs both strictly inside the limit
    always_comb begin
        dx  = (pac_x >= ghost_x) ? (pac_x - ghost_x) : (ghost_x - pac_x);
        dy  = (pac_y >= ghost_y) ? (pac_y - ghost_y) : (ghost_y - pac_y);
        hit = (dx < HIT_LIM) && (dy < HIT_LIM);
    end

endmodule

// File: rtl/game_status.sv
// rtl/game_status.sv - lives, score, pellets, collision and end-of-game sequencing
module game_status
    import game_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int PELLET_COUNT = 244,
    parameter int NUM_GHOSTS   = 4,
    parameter int HIT_DIST     = 8,
    parameter int DEATH_FRAMES = 60,
    parameter int END_FRAMES   = 120
) (
    input  logic          Clk,
    input  logic          Reset_n,
    game_status_if.slave  gs
);

    // Frame counter is 8 bits, so both frame counts must stay within 1..255
    localparam logic [2:0] LIVES_INIT   = 3'(LIVES);
    localparam logic [7:0] PELLETS_INIT = 8'(PELLET_COUNT);
    localparam logic [7:0] DEATH_LAST   = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] END_LAST     = 8'(END_FRAMES - 1);

    gs_state_t   state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [2:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  pellets_q, pellets_d;
    logic        game_won_q, game_won_d;
    logic        fail_q, fail_d;
    logic        finish_q, finish_d;
    logic        freeze_q, freeze_d;

    logic [NUM_GHOSTS-1:0] hit_vec;
    logic                  any_hit;

    logic [1:0]  eat_n;
    logic [16:0] pts;
    logic [16:0] score_sum;
    logic [15:0] score_add;
    logic [7:0]  pellets_sub;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_hit
        hit_detect #(.HIT_DIST(HIT_DIST)) u_hit (
            .pac_x   (gs.pac_x),
            .pac_y   (gs.pac_y),
            .ghost_x (gs.ghost_x[g*POS_W +: POS_W]),
            .ghost_y (gs.ghost_y[g*POS_W +: POS_W]),
            .hit     (hit_vec[g])
        );
    end

    assign any_hit = |hit_vec;

    // Saturating score and floored pellet count for this cycle's eat pulses
    always_comb begin
        eat_n       = {1'b0, gs.pellet_eaten} + {1'b0, gs.power_eaten};
        pts         = (gs.pellet_eaten ? 17'(PELLET_PTS) : 17'd0)
                    + (gs.power_eaten  ? 17'(POWER_PTS)  : 17'd0);
        score_sum   = {1'b0, score_q} + pts;
        score_add   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        pellets_sub = (pellets_q > {6'd0, eat_n}) ? (pellets_q - {6'd0, eat_n}) : 8'd0;
    end

    // Next-state: intro beats restart beats replay beats in-game events
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        lives_d     = lives_q;
        score_d     = score_q;
        pellets_d   = pellets_q;
        game_won_d  = game_won_q;
        fail_d      = 1'b0;
        finish_d    = 1'b0;

        if (gs.isIntro) begin
            state_d = IDLE;
        end else if (gs.restart) begin
            lives_d    = LIVES_INIT;
            score_d    = 16'd0;
            pellets_d  = PELLETS_INIT;
            game_won_d = 1'b0;
            state_d    = PLAY;
        end else if (gs.replay && state_q == WAIT_REPLAY) begin
            state_d = PLAY;
        end else begin
            case (state_q)
                PLAY: begin
                    // Pellets land first, so clearing the maze beats a same-cycle hit
                    score_d   = score_add;
                    pellets_d = pellets_sub;
                    if (pellets_sub == 8'd0) begin
                        state_d    = WON;
                        game_won_d = 1'b1;
                    end else if (gs.frame_tick && any_hit) begin
                        state_d = DYING;
                    end
                end
                DYING: begin
                    if (gs.frame_tick) begin
                        if (frame_cnt_q == DEATH_LAST) begin
                            if (lives_q > 3'd1) begin
                                lives_d = lives_q - 3'd1;
                                fail_d  = 1'b1;
                                state_d = WAIT_REPLAY;
                            end else begin
                                lives_d = 3'd0;
                                state_d = OVER;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                OVER, WON: begin
                    if (gs.frame_tick) begin
                        if (frame_cnt_q == END_LAST) begin
                            finish_d = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Every state entry (including restart into PLAY) starts a fresh count
        if (state_d != state_q || (gs.restart && !gs.isIntro)) begin
            frame_cnt_d = 8'd0;
        end

        freeze_d = (state_d != PLAY);
    end

    // State and registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= 8'd0;
            lives_q     <= 3'd0;
            score_q     <= 16'd0;
            pellets_q   <= 8'd0;
            game_won_q  <= 1'b0;
            fail_q      <= 1'b0;
            finish_q    <= 1'b0;
            freeze_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            pellets_q   <= pellets_d;
            game_won_q  <= game_won_d;
            fail_q      <= fail_d;
            finish_q    <= finish_d;
            freeze_q    <= freeze_d;
        end
    end

    assign gs.fail         = fail_q;
    assign gs.finish       = finish_q;
    assign gs.freeze       = freeze_q;
    assign gs.lives        = lives_q;
    assign gs.score        = score_q;
    assign gs.pellets_left = pellets_q;
    assign gs.game_won     = game_won_q;

endmodule
